// File: rtl/ifetch_bridge_if.sv
// Single-outstanding instruction bus: the bridge is master (req/addr), the memory side is slave.
// No flow control beyond req/gnt; responses are qualified by bus_rvalid.
interface ifetch_bridge_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_gnt,
    input  bus_rvalid,
    input  bus_rdata,
    input  bus_err
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_gnt,
    output bus_rvalid,
    output bus_rdata,
    output bus_err
  );
endinterface

// File: rtl/ifetch_bridge.sv
// Fetch bridge with a 2-entry word buffer and next-sequential prefetch; miss penalty 3 cycles on a zero-wait bus.
// The core is stalled through ifValid=0; bus_req is held until granted and never withdrawn.
module ifetch_bridge #(
  parameter bit PREFETCH = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     pcIn,
  input  logic            invalidate,
  output logic [31:0]     instr,
  output logic            ifValid,
  output logic            ifFault,
  ifetch_bridge_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       ent_vld;
  logic [1:0][28:0] ent_tag;
  logic [1:0][31:0] ent_dat;
  logic [31:0]      target;
  logic [31:0]      last_pc;
  logic             err_flt;
  logic             drop;

  logic [31:0]      next_pc;
  logic [31:0]      load_addr;
  logic             misaligned;
  logic             hit;
  logic             err_live;
  logic             nxt_buffered;
  logic             load;
  logic             resp;
  logic             do_write;
  logic             set_err;

  // The error fault only applies to the PC that was current when it was set.
  always_comb begin
    misaligned   = |pcIn[1:0];
    hit          = ent_vld[pcIn[2]] && (ent_tag[pcIn[2]] == pcIn[31:3]);
    err_live     = err_flt && (pcIn == last_pc);
    next_pc      = pcIn + 32'd4;
    nxt_buffered = ent_vld[next_pc[2]] && (ent_tag[next_pc[2]] == next_pc[31:3]);
    ifFault      = misaligned || err_live;
    ifValid      = hit && !ifFault;
    instr        = ent_dat[pcIn[2]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!misaligned) begin
          if (!hit && !err_live) begin
            state_nxt = S_REQ;
          end else if (PREFETCH && hit && !nxt_buffered) begin
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ:   if (bus.bus_gnt)    state_nxt = S_WAIT;
      S_WAIT:  if (bus.bus_rvalid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load      = (state == S_IDLE) && (state_nxt == S_REQ);
    load_addr = hit ? next_pc : pcIn;
    resp      = (state == S_WAIT) && bus.bus_rvalid;
    do_write  = resp && !bus.bus_err && !drop && !invalidate;
    set_err   = resp && bus.bus_err && !drop && !invalidate && (target == pcIn);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.bus_req  <= 1'b0;
      bus.bus_addr <= '0;
      target       <= '0;
      last_pc      <= '0;
      err_flt      <= 1'b0;
      drop         <= 1'b0;
      ent_vld      <= '0;
      ent_tag      <= '0;
      ent_dat      <= '0;
    end else begin
      bus.bus_req <= (state_nxt == S_REQ);
      last_pc     <= pcIn;
      if (load) begin
        target       <= load_addr;
        bus.bus_addr <= {load_addr[31:2], 2'b00};
      end
      // A response landing after an invalidate must not repopulate the buffer.
      drop <= (state_nxt != S_IDLE) && (drop || (invalidate && (state != S_IDLE)));
      if (invalidate) begin
        err_flt <= 1'b0;
      end else if (set_err) begin
        err_flt <= 1'b1;
      end else if (pcIn != last_pc) begin
        err_flt <= 1'b0;
      end
      if (invalidate) begin
        ent_vld <= '0;
      end else if (do_write) begin
        ent_vld[target[2]] <= 1'b1;
        ent_tag[target[2]] <= target[31:3];
        ent_dat[target[2]] <= bus.bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_bridge.sv
// Directed bench for ifetch_bridge: zero-wait bus responder, cycle-exact checks of fetch, prefetch, faults, invalidate and reset.
module tb_ifetch_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] pcIn;
  logic        invalidate;
  logic [31:0] instr;
  logic        ifValid;
  logic        ifFault;

  logic        err_en;
  logic [31:0] err_addr;
  logic        stray;

  int n_cmp = 0;
  int n_err = 0;

  ifetch_bridge_if bif ();

  ifetch_bridge #(.PREFETCH(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .pcIn       (pcIn),
    .invalidate (invalidate),
    .instr      (instr),
    .ifValid    (ifValid),
    .ifFault    (ifFault),
    .bus        (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bif.bus_gnt = bif.bus_req;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a ^ 32'h5A5A_0000) + 32'd1;
  endfunction

  // Response arrives in the cycle after the grant.
  initial begin
    logic        fire;
    logic [31:0] a;
    bif.bus_rvalid = 1'b0;
    bif.bus_rdata  = '0;
    bif.bus_err    = 1'b0;
    forever begin
      @(negedge clk);
      fire = bif.bus_req && bif.bus_gnt;
      a    = bif.bus_addr;
      @(posedge clk);
      #1;
      if (fire) begin
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = word_of(a);
        bif.bus_err    = err_en && (a == err_addr);
      end else if (stray) begin
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'hDEAD_BEEF;
        bif.bus_err    = 1'b0;
      end else begin
        bif.bus_rvalid = 1'b0;
        bif.bus_rdata  = '0;
        bif.bus_err    = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    pcIn       = 32'h0;
    invalidate = 1'b0;
    err_en     = 1'b0;
    err_addr   = 32'h0;
    stray      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req",    {31'd0, bif.bus_req}, 32'd0);
    chk("rst_addr",   bif.bus_addr,         32'h0);
    chk("rst_valid",  {31'd0, ifValid},     32'd0);
    chk("rst_instr",  instr,                32'h0);
    chk("rst_fault",  {31'd0, ifFault},     32'd0);
    pcIn = 32'h2;
    #1 chk("rst_fault_misal", {31'd0, ifFault}, 32'd1);
    pcIn = 32'h0;

    // Demand miss at 0x0
    cyc(); rst = 1'b1; #1;
    chk("t0_valid", {31'd0, ifValid},     32'd0);
    chk("t0_req",   {31'd0, bif.bus_req}, 32'd0);
    cyc(); #1;
    chk("t1_req",   {31'd0, bif.bus_req}, 32'd1);
    chk("t1_addr",  bif.bus_addr,         32'h0);
    cyc(); #1;
    chk("t2_valid", {31'd0, ifValid},     32'd0);
    cyc(); #1;
    chk("t3_valid", {31'd0, ifValid},     32'd1);
    chk("t3_instr", instr,                32'h0000_0013);
    cyc(); #1;
    chk("pf4_req",  {31'd0, bif.bus_req}, 32'd1);
    chk("pf4_addr", bif.bus_addr,         32'h4);
    cyc();

    // Sequential hit on 0x4, then redirect to 0x100 while prefetch 0x8 is in flight
    cyc(); pcIn = 32'h4; #1;
    chk("hit4_valid", {31'd0, ifValid}, 32'd1);
    chk("hit4_instr", instr,            32'h5A5A_0005);
    cyc(); #1;
    chk("pf8_req",  {31'd0, bif.bus_req}, 32'd1);
    chk("pf8_addr", bif.bus_addr,         32'h8);
    cyc(); pcIn = 32'h100; #1;
    chk("br_wait_valid", {31'd0, ifValid}, 32'd0);
    cyc(); #1;
    chk("br_idle_valid", {31'd0, ifValid}, 32'd0);
    cyc(); pcIn = 32'h8; #1;
    chk("br_req",      {31'd0, bif.bus_req}, 32'd1);
    chk("br_addr",     bif.bus_addr,         32'h100);
    chk("pf8_written", {31'd0, ifValid},     32'd1);
    chk("pf8_instr",   instr,                32'h5A5A_0009);
    cyc(); pcIn = 32'h100; #1;
    chk("br_resp_valid", {31'd0, ifValid}, 32'd0);
    cyc(); #1;
    chk("br_valid", {31'd0, ifValid}, 32'd1);
    chk("br_instr", instr,            32'h5A5A_0101);
    repeat (4) cyc();

    // Wrap-around prefetch from 0xFFFFFFFC to 0x0
    cyc(); pcIn = 32'hFFFF_FFFC; #1;
    chk("wr_miss", {31'd0, ifValid}, 32'd0);
    cyc(); #1;
    chk("wr_req",  {31'd0, bif.bus_req}, 32'd1);
    chk("wr_addr", bif.bus_addr,         32'hFFFF_FFFC);
    cyc();
    cyc(); #1;
    chk("wr_valid", {31'd0, ifValid}, 32'd1);
    chk("wr_instr", instr,            32'hA5A5_FFFD);
    cyc(); #1;
    chk("wr_pf_req",  {31'd0, bif.bus_req}, 32'd1);
    chk("wr_pf_addr", bif.bus_addr,         32'h0);
    cyc();
    cyc(); pcIn = 32'h0; #1;
    chk("wr0_valid", {31'd0, ifValid},     32'd1);
    chk("wr0_instr", instr,                32'h0000_0013);
    chk("wr0_noreq", {31'd0, bif.bus_req}, 32'd0);
    repeat (5) cyc();

    // Bus error on demand fetch of 0x40, then prefetch error on 0x48
    err_en   = 1'b1;
    err_addr = 32'h40;
    cyc(); pcIn = 32'h40; #1;
    cyc(); #1;
    chk("e40_req",  {31'd0, bif.bus_req}, 32'd1);
    chk("e40_addr", bif.bus_addr,         32'h40);
    cyc();
    cyc(); #1;
    chk("e40_fault", {31'd0, ifFault}, 32'd1);
    chk("e40_valid", {31'd0, ifValid}, 32'd0);
    cyc(); #1;
    chk("e40_noretry", {31'd0, bif.bus_req}, 32'd0);
    chk("e40_fault2",  {31'd0, ifFault},     32'd1);
    cyc(); pcIn = 32'h44; err_addr = 32'h48; #1;
    chk("e44_fault_clr", {31'd0, ifFault}, 32'd0);
    cyc(); #1;
    chk("e44_req",  {31'd0, bif.bus_req}, 32'd1);
    chk("e44_addr", bif.bus_addr,         32'h44);
    cyc();
    cyc(); #1;
    chk("e44_valid", {31'd0, ifValid}, 32'd1);
    chk("e44_instr", instr,            32'h5A5A_0045);
    cyc(); #1;
    chk("e48_pf_addr", bif.bus_addr, 32'h48);
    cyc();
    cyc(); err_en = 1'b0; #1;
    chk("e48_pf_fault", {31'd0, ifFault}, 32'd0);
    chk("e48_pf_valid", {31'd0, ifValid}, 32'd1);
    repeat (4) cyc();

    // Misaligned PC: fault, no bus traffic
    cyc(); pcIn = 32'h2;
    repeat (4) cyc();
    #1 chk("mis_fault", {31'd0, ifFault}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      chk("mis_noreq", {31'd0, bif.bus_req}, 32'd0);
    end

    // Invalidate coinciding with the response
    cyc(); pcIn = 32'h200; #1;
    chk("inv_miss", {31'd0, ifValid}, 32'd0);
    cyc(); #1;
    chk("inv_req",  {31'd0, bif.bus_req}, 32'd1);
    chk("inv_addr", bif.bus_addr,         32'h200);
    cyc(); invalidate = 1'b1;
    cyc(); invalidate = 1'b0; #1;
    chk("inv_nowrite", {31'd0, ifValid}, 32'd0);
    cyc(); #1;
    chk("inv_refetch_req",  {31'd0, bif.bus_req}, 32'd1);
    chk("inv_refetch_addr", bif.bus_addr,         32'h200);
    cyc();
    cyc(); #1;
    chk("inv_valid", {31'd0, ifValid}, 32'd1);
    chk("inv_instr", instr,            32'h5A5A_0201);

    // Async reset while the 0x204 prefetch is in WAIT, stray response after release
    cyc();
    cyc(); #1; rst = 1'b0; stray = 1'b1; #1;
    chk("mrst_req",   {31'd0, bif.bus_req}, 32'd0);
    chk("mrst_addr",  bif.bus_addr,         32'h0);
    chk("mrst_valid", {31'd0, ifValid},     32'd0);
    chk("mrst_instr", instr,                32'h0);
    chk("mrst_fault", {31'd0, ifFault},     32'd0);
    cyc(); rst = 1'b1; pcIn = 32'h2; #1;
    stray = 1'b0;
    cyc(); pcIn = 32'h0; #1;
    chk("stray_nowrite", {31'd0, ifValid},     32'd0);
    chk("stray_noreq",   {31'd0, bif.bus_req}, 32'd0);
    cyc(); #1;
    chk("post_req",  {31'd0, bif.bus_req}, 32'd1);
    chk("post_addr", bif.bus_addr,         32'h0);
    cyc();
    cyc(); #1;
    chk("post_valid", {31'd0, ifValid}, 32'd1);
    chk("post_instr", instr,            32'h0000_0013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_bridge.md
# ifetch_bridge

Instruction-fetch bridge between the core's fetch port and a single-outstanding instruction bus. It turns the core's program counter into bus reads and keeps a 2-entry word buffer with optional next-sequential prefetch. It drives `instr`/`ifValid` so that the core stalls fetch whenever `ifValid` is low. It also reports bus errors and misaligned PCs as a fetch fault.

## Interface
- `PREFETCH`, default 1: 1 enables next-sequential prefetch into the idle buffer entry; 0 fetches on demand only.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: **asynchronous, active-low** reset; while low, all state is held at its reset value.
- `pcIn` in 32: core fetch PC; the core holds it stable while `ifValid`=0.
- `invalidate` in 1: one-cycle pulse; clears both buffer entries (fence.i).
- `instr` out 32: instruction word at `pcIn`; meaningful only when `ifValid`=1.
- `ifValid` out 1: `instr` is the word stored at `pcIn`.
- `ifFault` out 1: `pcIn` is misaligned, or its fetch returned a bus error.
- `bus_req` out 1: read request, held until granted.
- `bus_addr` out 32: request word address; bits [1:0] are always 0.
- `bus_gnt` in 1: request accepted in any cycle with `bus_req`=1 and `bus_gnt`=1.
- `bus_rvalid` in 1: read response valid; arrives one or more cycles after the grant.
- `bus_rdata` in 32: response data.
- `bus_err` in 1: response is an error; qualified by `bus_rvalid`.

## Operation
- Buffer: entry e∈{0,1} holds `{valid, tag[28:0], data[31:0]}` for the word whose `addr[2]`=e; tag = `addr[31:3]`.
- Hit: `entry[pcIn[2]].valid` and `tag == pcIn[31:3]`.
  - `ifValid` = hit & !`ifFault`.
  - `instr` = `entry[pcIn[2]].data`.
  - Both are combinational from `pcIn` and registered state.
- FSM states:
  - IDLE: no bus activity.
  - REQ: `bus_req`=1, waiting for `bus_gnt`.
  - WAIT: waiting for `bus_rvalid`.
- IDLE decision, first match wins:
  1. `pcIn[1:0]`≠0: no request; `ifFault`=1.
  2. Demand miss with no fault: load target=`pcIn`, go to REQ.
  3. `PREFETCH`=1, hit, and `pcIn+4` not already buffered: load target=`pcIn+4` (32-bit wrap, 0xFFFFFFFC→0x00000000), go to REQ.
  4. Otherwise stay in IDLE.
- REQ→WAIT on `bus_gnt`. The request cannot be withdrawn; `bus_addr` stays stable until granted.
- WAIT→IDLE on `bus_rvalid`:
  - `bus_err`=0 and no drop flag: write `{1, target[31:3], bus_rdata}` into `entry[target[2]]`, even if `pcIn` has since moved (the word remains correct).
  - `bus_err`=1: no write. If target equals the current `pcIn`, set the error-fault register. Prefetch errors are otherwise silent.
- `invalidate`:
  - Clears both valid bits and the error-fault register.
  - In REQ or WAIT, also sets a drop flag so the pending response is discarded; the flag clears on return to IDLE.
  - If a response and `invalidate` arrive in the same cycle, `invalidate` wins: nothing is written.
- `ifFault` = `pcIn[1:0]`≠0 OR error-fault register. The register clears on any change of `pcIn`.
- `bus_rvalid` outside WAIT is ignored.

## Timing
- Reset values:
  - `bus_req`=0, `bus_addr`=0.
  - Both entries invalid, so `ifValid`=0 and `instr`=0 (entry data resets to 0).
  - Error-fault register 0, drop flag 0, state IDLE.
- `ifFault` after reset follows `pcIn` alignment only.
- `bus_req` and `bus_addr` are registered.
- Demand-miss penalty with a zero-wait bus (grant in the request cycle, response one cycle later):
  - Miss visible in cycle t.
  - `bus_req`=1 in t+1.
  - `bus_rvalid` in t+2.
  - `ifValid`=1 in t+3.
- No response-to-`instr` bypass.
- Sequential stream with `PREFETCH`=1 and the same bus: the prefetch is issued the cycle after a hit. The next word is ready 3 cycles after the hit is first seen, which sustains one instruction every 3 cycles.
- At most one transaction is outstanding.
- A `pcIn` change during REQ or WAIT never aborts the bus transaction. A new demand is decided in the IDLE cycle after completion.
- Reset asserted mid-transaction: state returns to IDLE immediately. A late `bus_rvalid` after reset release is ignored because the FSM is not in WAIT.

## Test plan
- Reset, then `pcIn`=0x0, 1-cycle-grant / 1-cycle-response bus returning 0x00000013 -> `bus_req`=1 with `bus_addr`=0x0 at t+1, `ifValid`=1 with `instr`=0x00000013 at t+3, then a prefetch request for 0x4.
- Branch redirect: `pcIn` changes to 0x100 while the prefetch for 0x8 is in WAIT -> 0x8 is completed and written; the next request is 0x100; `ifValid` stays low until 0x100 data is stored.
- Wrap-around: `pcIn`=0xFFFFFFFC hits -> prefetch `bus_addr`=0x00000000 goes to entry 0; `pcIn`=0x0 then hits with no new demand request.
- Error: `bus_err`=1 on a demand fetch of 0x40 -> `ifFault`=1 and `ifValid`=0; `pcIn`→0x44 clears `ifFault` and issues 0x44. A prefetch error leaves `ifFault`=0.
- `pcIn`=0x2 -> `ifFault`=1, no `bus_req` for 8 cycles.
- `invalidate` in the same cycle as `bus_rvalid` -> no entry written, `ifValid`=0, and a refetch of `pcIn` is issued. Async reset low during WAIT -> all outputs 0 immediately, and a stray `bus_rvalid` after release is ignored.
